// File: rtl/tick_1s_pkg.sv
// Shared project constants for timebase users.
// Blocks that instantiate tick_1s pass SYS_CLK_HZ to its CLK_HZ parameter.
package tick_1s_pkg;

   localparam int unsigned SYS_CLK_HZ = 50_000_000;

   // Clock cycles per tick; integer division, remainder discarded.
   function automatic int unsigned tick_div(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/tick_1s.sv
// Free-running timebase: one-cycle strobe every DIV enabled clocks, plus an
// 8-bit wrapping count of strobes issued.
module tick_1s
   import tick_1s_pkg::*;
#(
   parameter int unsigned CLK_HZ  = SYS_CLK_HZ,
   parameter int unsigned TICK_HZ = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       s,
   output logic [7:0] sec
);

   localparam int unsigned DIV  = tick_div(CLK_HZ, TICK_HZ);
   localparam int unsigned CW   = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("tick_1s: CLK_HZ / TICK_HZ must be at least 2");
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic          s_q, s_d;
   logic [7:0]    sec_q, sec_d;

   // Dropping en freezes the phase; the strobe is deferred, never lost.
   always_comb begin
      cnt_d = cnt_q;
      sec_d = sec_q;
      s_d   = 1'b0;
      if (en) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            s_d   = 1'b1;
            sec_d = sec_q + 8'd1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         s_q   <= 1'b0;
         sec_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
         s_q   <= s_d;
         sec_q <= sec_d;
      end
   end

   assign s   = s_q;
   assign sec = sec_q;

endmodule

// File: tb/tb_tick_1s.sv
// Directed + randomized checks of tick_1s at DIV = 10, 2 and 7 against a
// count-of-enabled-cycles reference model.
module tb_tick_1s;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en10 = 1'b0, en2 = 1'b0, en7 = 1'b0;
   logic s10, s2, s7;
   logic [7:0] sec10, sec2, sec7;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n10 = 0, n2 = 0, n7 = 0;
   logic e10 = 1'b0, e2 = 1'b0, e7 = 1'b0;

   always #5 clk = ~clk;

   tick_1s #(.CLK_HZ(10), .TICK_HZ(1)) u10 (.clk(clk), .rst_n(rst_n), .en(en10), .s(s10), .sec(sec10));
   tick_1s #(.CLK_HZ(2),  .TICK_HZ(1)) u2  (.clk(clk), .rst_n(rst_n), .en(en2),  .s(s2),  .sec(sec2));
   tick_1s #(.CLK_HZ(21), .TICK_HZ(3)) u7  (.clk(clk), .rst_n(rst_n), .en(en7),  .s(s7),  .sec(sec7));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Model: strobe whenever the running count of enabled edges since reset
   // reaches a multiple of DIV; sec is that multiple, modulo 256.
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         n10 = 0; n2 = 0; n7 = 0;
         e10 = 1'b0; e2 = 1'b0; e7 = 1'b0;
      end else begin
         if (en10) n10++;
         if (en2)  n2++;
         if (en7)  n7++;
         e10 = en10 && (n10 % 10 == 0);
         e2  = en2  && (n2  % 2  == 0);
         e7  = en7  && (n7  % 7  == 0);
      end
      cyc++;
      #1;
      check("s10", 32'(s10), 32'(e10));
      check("sec10", 32'(sec10), 32'((n10 / 10) % 256));
      check("s2", 32'(s2), 32'(e2));
      check("sec2", 32'(sec2), 32'((n2 / 2) % 256));
      check("s7", 32'(s7), 32'(e7));
      check("sec7", 32'(sec7), 32'((n7 / 7) % 256));
   endtask

   // Called at #1 after an edge: assert, check async clear, hold, release.
   task automatic do_reset();
      rst_n = 1'b0;
      n10 = 0; n2 = 0; n7 = 0;
      #1;
      check("rst_async_s10", 32'(s10), 32'd0);
      check("rst_async_sec10", 32'(sec10), 32'd0);
      check("rst_async_sec2", 32'(sec2), 32'd0);
      check("rst_async_sec7", 32'(sec7), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      int found;

      // Reset state while held in reset with enables high.
      en10 = 1'b1; en2 = 1'b1; en7 = 1'b1;
      repeat (3) step();
      #1;
      rst_n = 1'b1;
      cyc = 0;

      // Basic period: strobes at 10, 20, 30; DIV=2 alternates.
      repeat (30) step();
      check("basic_sec10_after_30", 32'(sec10), 32'd3);
      check("basic_sec2_after_30", 32'(sec2), 32'd15);

      // Enable gating: en low on edges 4..8, next strobe on edge 15.
      do_reset();
      en10 = 1'b1;
      repeat (3) step();
      en10 = 1'b0;
      repeat (5) step();
      en10 = 1'b1;
      repeat (6) step();
      check("gate_no_strobe_14", 32'(s10), 32'd0);
      step();
      check("gate_strobe_15", 32'(s10), 32'd1);

      // Wrap at DIV=2 with random enables on the other instances.
      do_reset();
      en2 = 1'b1;
      for (int i = 0; i < 512; i++) begin
         en10 = 1'($urandom_range(0, 3) != 0);
         en7  = 1'($urandom_range(0, 1));
         step();
         if (i == 509) check("wrap_sec2_255", 32'(sec2), 32'd255);
      end
      check("wrap_sec2_zero", 32'(sec2), 32'd0);
      check("wrap_s2_high", 32'(s2), 32'd1);

      // Randomized enables on all instances.
      for (int i = 0; i < 600; i++) begin
         en10 = 1'($urandom_range(0, 1));
         en2  = 1'($urandom_range(0, 2) != 0);
         en7  = 1'($urandom_range(0, 4) != 0);
         step();
      end

      // Async reset right on a strobe cycle, then a full period after release.
      en10 = 1'b1; en2 = 1'b1; en7 = 1'b1;
      found = 0;
      for (int i = 0; i < 25 && found == 0; i++) begin
         step();
         if (e10 && n10 >= 20) found = 1;
      end
      check("find_strobe_bound", 32'(found), 32'd1);
      check("pre_rst_s10", 32'(s10), 32'd1);
      do_reset();
      repeat (9) step();
      check("post_rst_no_strobe_9", 32'(s10), 32'd0);
      step();
      check("post_rst_strobe_10", 32'(s10), 32'd1);
      check("post_rst_sec10", 32'(sec10), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
